// File: rtl/vga_timing_rx_pkg.sv
// Shared VGA timing constants (1024x768 @ 1344x806), coordinate widths and the
// lock FSM state type used by the timing receiver.
package vga_pkg;

    localparam int H_ACTIVE = 1024;
    localparam int H_FP     = 24;
    localparam int H_SYNC   = 136;
    localparam int H_BP     = 160;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 768;
    localparam int V_FP     = 3;
    localparam int V_SYNC   = 6;
    localparam int V_BP     = 29;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } vga_state_e;

    function automatic logic [X_W-1:0] sat_inc_x(input logic [X_W-1:0] v);
        return (v == '1) ? v : v + X_W'(1);
    endfunction

    function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] v);
        return (v == '1) ? v : v + Y_W'(1);
    endfunction

endpackage

// File: rtl/vga_timing_rx_if.sv
// Video-in / timing-out bundle for vga_timing_rx; the source is the master.
// o_err_cnt exists only when VGA_TIMING_RX_ERR_CNT_EN is defined.
interface vga_timing_rx_if;
    import vga_pkg::*;

    logic           i_hs;
    logic           i_vs;
    logic           i_de;
    logic [X_W-1:0] o_x;
    logic [Y_W-1:0] o_y;
    logic           o_pix_valid;
    logic [X_W-1:0] o_h_total;
    logic [Y_W-1:0] o_v_total;
    logic           o_locked;
    logic           o_frame_start;
    logic           o_err;
`ifdef VGA_TIMING_RX_ERR_CNT_EN
    logic [15:0]    o_err_cnt;
`endif

    modport master (
        output i_hs, i_vs, i_de,
        input  o_x, o_y, o_pix_valid, o_h_total, o_v_total,
               o_locked, o_frame_start, o_err
`ifdef VGA_TIMING_RX_ERR_CNT_EN
        , input o_err_cnt
`endif
    );

    modport slave (
        input  i_hs, i_vs, i_de,
        output o_x, o_y, o_pix_valid, o_h_total, o_v_total,
               o_locked, o_frame_start, o_err
`ifdef VGA_TIMING_RX_ERR_CNT_EN
        , output o_err_cnt
`endif
    );

endinterface

// File: rtl/vga_edge_sync.sv
// Two-flop input register with polarity correction and leading/trailing edge
// detect; o_lvl is the registered, active-high copy everything else keys off.
module vga_edge_sync #(
    parameter bit ACT_LOW = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    logic s1, s2, prv;

    // Flops hold the corrected level, so reset (0) is the inactive level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            prv <= 1'b0;
        end else begin
            s1  <= i_sig ^ ACT_LOW;
            s2  <= s1;
            prv <= s2;
        end
    end

    assign o_lvl  = s2;
    assign o_rise = s2 & ~prv;
    assign o_fall = ~s2 & prv;

endmodule

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: measures line/frame length, locks after LOCK_FRAMES good
// frames, emits pixel coordinates. Define VGA_TIMING_RX_ERR_CNT_EN for o_err_cnt.
module vga_timing_rx import vga_pkg::*; #(
    parameter int H_TOTAL_EXP  = H_TOTAL,
    parameter int V_TOTAL_EXP  = V_TOTAL,
    parameter int LOCK_FRAMES  = 2,
    parameter int SYNC_ACT_LOW = 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    vga_timing_rx_if.slave bus
);

    localparam logic [X_W-1:0] H_EXP  = X_W'(H_TOTAL_EXP);
    localparam logic [Y_W-1:0] V_EXP  = Y_W'(V_TOTAL_EXP);
    localparam logic [3:0]     LOCK_N = 4'(LOCK_FRAMES);

    logic [2:0] raw, lvl, rise, fall;
    logic       hs_rise, vs_rise, de_lvl, de_rise, de_fall;
    logic       sync_unused;

    assign raw = {bus.i_de, bus.i_vs, bus.i_hs};

    // Index 0/1 are hsync/vsync (polarity per SYNC_ACT_LOW), index 2 is de.
    for (genvar i = 0; i < 3; i++) begin : g_sync
        vga_edge_sync #(.ACT_LOW((i != 2) && (SYNC_ACT_LOW != 0))) u_sync (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_sig   (raw[i]),
            .o_lvl   (lvl[i]),
            .o_rise  (rise[i]),
            .o_fall  (fall[i])
        );
    end

    assign hs_rise     = rise[0];
    assign vs_rise     = rise[1];
    assign de_lvl      = lvl[2];
    assign de_rise     = rise[2];
    assign de_fall     = fall[2];
    assign sync_unused = ^{lvl[1:0], fall[1:0]};

    vga_state_e     state;
    logic [X_W-1:0] h_cnt, h_len;
    logic [Y_W-1:0] v_cnt, v_len;
    logic [3:0]     match_cnt;
    logic           frame_bad, de_q;
    logic           line_bad, frame_ok, h_sat_ev, lock_err;

    assign h_len    = sat_inc_x(h_cnt);
    assign v_len    = sat_inc_y(v_cnt);
    assign line_bad = hs_rise && (h_len != H_EXP);
    // A bad last line, coincident with the vsync edge, still spoils the frame.
    assign frame_ok = !frame_bad && !line_bad && (v_len == V_EXP);
    assign h_sat_ev = !hs_rise && (h_len == '1) && (h_cnt != '1);
    assign lock_err = (state == LOCKED) &&
                      (line_bad || (vs_rise && (v_len != V_EXP)) || h_sat_ev);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt             <= '0;
            v_cnt             <= '0;
            de_q              <= 1'b0;
            bus.o_h_total     <= '0;
            bus.o_v_total     <= '0;
            bus.o_x           <= '0;
            bus.o_y           <= '0;
            bus.o_frame_start <= 1'b0;
        end else begin
            h_cnt <= hs_rise ? '0 : h_len;
            if (hs_rise)
                bus.o_h_total <= h_len;
            if (vs_rise) begin
                v_cnt         <= '0;
                bus.o_v_total <= v_len;
            end else if (hs_rise) begin
                v_cnt <= v_len;
            end
            if (de_rise)
                bus.o_x <= '0;
            else if (de_lvl)
                bus.o_x <= bus.o_x + X_W'(1);
            if (vs_rise)
                bus.o_y <= '0;
            else if (de_fall)
                bus.o_y <= bus.o_y + Y_W'(1);
            de_q              <= de_lvl;
            bus.o_frame_start <= vs_rise;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= SEARCH;
            match_cnt    <= '0;
            frame_bad    <= 1'b0;
            bus.o_locked <= 1'b0;
            bus.o_err    <= 1'b0;
        end else begin
            bus.o_err <= lock_err;
            case (state)
                SEARCH: begin
                    if (vs_rise) begin
                        state     <= ACQUIRE;
                        match_cnt <= '0;
                        frame_bad <= 1'b0;
                    end
                end
                ACQUIRE: begin
                    if (vs_rise) begin
                        frame_bad <= 1'b0;
                        if (frame_ok) begin
                            match_cnt <= match_cnt + 4'd1;
                            if (match_cnt + 4'd1 == LOCK_N) begin
                                state        <= LOCKED;
                                bus.o_locked <= 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end else if (line_bad) begin
                        frame_bad <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (lock_err) begin
                        state        <= SEARCH;
                        bus.o_locked <= 1'b0;
                    end
                end
                default: begin
                    state        <= SEARCH;
                    bus.o_locked <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_pix_valid = de_q & bus.o_locked;

`ifdef VGA_TIMING_RX_ERR_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            bus.o_err_cnt <= '0;
        else if (lock_err && (bus.o_err_cnt != '1))
            bus.o_err_cnt <= bus.o_err_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx on a small 28x12 raster; one instance takes
// active-low syncs, the other active-high copies of the same waveform.
module tb_vga_timing_rx;

    localparam int HA = 16, HF = 2, HS = 4, HB = 6;
    localparam int HT = HA + HF + HS + HB;   // 28
    localparam int VA = 6, VF = 1, VS = 2, VB = 3;
    localparam int VT = VA + VF + VS + VB;   // 12

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_timing_rx_if n_if ();
    vga_timing_rx_if p_if ();

    vga_timing_rx #(.H_TOTAL_EXP(HT), .V_TOTAL_EXP(VT), .LOCK_FRAMES(2), .SYNC_ACT_LOW(1)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (n_if)
    );

    vga_timing_rx #(.H_TOTAL_EXP(HT), .V_TOTAL_EXP(VT), .LOCK_FRAMES(2), .SYNC_ACT_LOW(0)) u_dut_pos (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (p_if)
    );

    logic [45:0] n_outs, p_outs;
    assign n_outs = {n_if.o_x, n_if.o_y, n_if.o_pix_valid, n_if.o_h_total, n_if.o_v_total,
                     n_if.o_locked, n_if.o_frame_start, n_if.o_err};
    assign p_outs = {p_if.o_x, p_if.o_y, p_if.o_pix_valid, p_if.o_h_total, p_if.o_v_total,
                     p_if.o_locked, p_if.o_frame_start, p_if.o_err};

    int n_chk = 0, n_fail = 0;
    int cyc = 0, fs_n = 0, fs1_cyc = -1, err_n = 0, err_cyc = -1;
    int lock_cyc = -1, lock_fs = -1, p_lock_cyc = -1;
    int pv_n = 0, fx = -1, fy = -1, lx = -1, ly = -1;
    bit lock_fs_hit = 1'b0, lk_d = 1'b0, plk_d = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One pixel clock: sample outputs at the falling edge, then drive the next inputs.
    task automatic tick(input bit hs, input bit vs, input bit de);
        @(negedge clk);
        cyc++;
        if (n_if.o_frame_start) begin
            fs_n++;
            if (fs_n == 1) fs1_cyc = cyc;
        end
        if (n_if.o_err) begin
            err_n++;
            err_cyc = cyc;
        end
        if (n_if.o_locked && !lk_d) begin
            lock_cyc    = cyc;
            lock_fs     = fs_n;
            lock_fs_hit = n_if.o_frame_start;
        end
        if (p_if.o_locked && !plk_d) p_lock_cyc = cyc;
        lk_d  = n_if.o_locked;
        plk_d = p_if.o_locked;
        if (n_if.o_pix_valid) begin
            if (pv_n == 0) begin
                fx = int'(n_if.o_x);
                fy = int'(n_if.o_y);
            end
            lx = int'(n_if.o_x);
            ly = int'(n_if.o_y);
            pv_n++;
        end
        n_if.i_hs = ~hs;
        n_if.i_vs = ~vs;
        n_if.i_de = de;
        p_if.i_hs = hs;
        p_if.i_vs = vs;
        p_if.i_de = de;
    endtask

    task automatic line(input int len, input bit vs_on, input bit de_on);
        for (int c = 0; c < len; c++)
            tick(c < HS, vs_on, de_on && (c >= HS + HB) && (c < HS + HB + HA));
    endtask

    // Lines first_ln..end_ln-1 of a frame; line short_ln is one clock short.
    task automatic frame(input int short_ln, input int first_ln, input int end_ln);
        for (int l = first_ln; l < end_ln; l++)
            line((l == short_ln) ? HT - 1 : HT, l < VS, (l >= VS + VB) && (l < VS + VB + VA));
    endtask

    int a0, c0, g0, g11, j0, n0;

    initial begin
        n_if.i_hs = 1'b1; n_if.i_vs = 1'b1; n_if.i_de = 1'b0;
        p_if.i_hs = 1'b0; p_if.i_vs = 1'b0; p_if.i_de = 1'b0;
        repeat (3) tick(0, 0, 0);
        chk("rst_outs_n", n_outs, 0);
        chk("rst_outs_p", p_outs, 0);
        rst_n = 1'b1;
        repeat (5) tick(0, 0, 0);

        // Initial lock: first vsync, then two good frames.
        a0 = cyc + 1;
        frame(-1, 0, VT);
        frame(-1, 0, VT);
        c0 = cyc + 1;
        pv_n = 0;
        frame(-1, 0, VT);
        chk("fs1_latency", fs1_cyc, a0 + 3);
        chk("lock_cyc", lock_cyc, c0 + 3);
        chk("lock_at_fs3", lock_fs, 3);
        chk("lock_with_fs", lock_fs_hit, 1);
        chk("p_lock_cyc", p_lock_cyc, c0 + 3);
        chk("h_total_n", n_if.o_h_total, HT);
        chk("v_total_n", n_if.o_v_total, VT);
        chk("h_total_p", p_if.o_h_total, HT);
        chk("v_total_p", p_if.o_v_total, VT);
        chk("pix_count", pv_n, HA * VA);
        chk("first_x", fx, 0);
        chk("first_y", fy, 0);
        chk("last_x", lx, HA - 1);
        chk("last_y", ly, VA - 1);

        // Short line while locked, then relock after two good frames.
        frame(3, 0, VT);
        chk("short_err_once", err_n, 1);
        chk("short_unlock", n_if.o_locked, 0);
        frame(-1, 0, VT);
        frame(-1, 0, VT);
        g0 = cyc + 1;
        frame(-1, 0, VT);
        chk("relock_cyc", lock_cyc, g0 + 3);
        chk("short_err_total", err_n, 1);

        // Loss of hsync while locked.
        g11 = cyc - HT + 1;
        repeat (2100) tick(0, 0, 0);
        chk("hloss_err_n", err_n, 2);
        chk("hloss_err_cyc", err_cyc, g11 + 3 + 2047);
        chk("hloss_unlock", n_if.o_locked, 0);
        frame(-1, 0, 1);
        chk("h_total_sat", n_if.o_h_total, 2047);
        frame(-1, 1, VT);

        // Relock, then a short frame.
        frame(-1, 0, VT);
        j0 = cyc + 1;
        frame(-1, 0, VT - 1);
        chk("lock3_cyc", lock_cyc, j0 + 3);
        frame(-1, 0, 7);
        line(14, 1'b0, 1'b1);
        chk("vshort_err_n", err_n, 3);
        chk("vshort_unlock", n_if.o_locked, 0);
        chk("pre_rst_h_total", n_if.o_h_total, HT);
`ifdef VGA_TIMING_RX_ERR_CNT_EN
        chk("err_cnt_n", n_if.o_err_cnt, 3);
        chk("err_cnt_p", p_if.o_err_cnt, 3);
`endif

        // Asynchronous reset in the middle of a line.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_n", n_outs, 0);
        chk("async_rst_p", p_outs, 0);
`ifdef VGA_TIMING_RX_ERR_CNT_EN
        chk("async_rst_cnt_n", n_if.o_err_cnt, 0);
        chk("async_rst_cnt_p", p_if.o_err_cnt, 0);
`endif
        repeat (3) tick(0, 0, 0);
        rst_n = 1'b1;
        repeat (4) tick(0, 0, 0);
        frame(-1, 0, VT);
        frame(-1, 0, VT);
        n0 = cyc + 1;
        frame(-1, 0, VT);
        chk("post_rst_lock", lock_cyc, n0 + 3);
        chk("post_rst_p_lock", p_lock_cyc, n0 + 3);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_rx.md
VGA_TIMING_RX -- requirements
Module: vga_timing_rx

Interface
REQ-001 SHALL have parameter H_TOTAL_EXP, default 1344, expected pixel clocks per line.
REQ-002 SHALL have parameter V_TOTAL_EXP, default 806, expected lines per frame.
REQ-003 SHALL have parameter LOCK_FRAMES, default 2, consecutive matching frames required to lock (range 1..15).
REQ-004 SHALL have parameter SYNC_ACT_LOW, default 1, where 1 means the hsync and vsync inputs are active-low.
REQ-005 i_clk  input  1  pixel clock; the single clock for the block; all logic on its rising edge.
REQ-006 i_rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-007 i_hs, i_vs, i_de  input  1 each  incoming horizontal sync, vertical sync and display enable.
REQ-008 o_x  output  11  active-pixel column; o_y  output  10  active-line row.
REQ-009 o_pix_valid  output  1  high when o_x/o_y address a real pixel and o_locked=1.
REQ-010 o_h_total  output  11  last measured line length in clocks; o_v_total  output  10  last measured frame length in lines.
REQ-011 o_locked  output  1  lock status; o_frame_start  output  1  one-cycle pulse at each vsync leading edge; o_err  output  1  one-cycle pulse when lock is lost.

Function
REQ-012 i_hs, i_vs and i_de SHALL each pass through a 2-flop input register; all outputs are referenced to these registered copies (2-cycle input latency).
REQ-013 Sync leading edge SHALL mean the inactive-to-active transition after polarity correction by SYNC_ACT_LOW.
REQ-014 h_cnt: set to 0 on the cycle an hsync leading edge is detected, otherwise +1, saturating at 2047.
REQ-015 On each hsync edge, o_h_total SHALL load h_cnt+1 (11-bit, saturating at 2047) on the next cycle.
REQ-016 v_cnt: set to 0 on vsync edge, +1 on each hsync edge, saturating at 1023; on vsync edge, o_v_total SHALL load v_cnt+1.
REQ-017 o_x SHALL be 0 on the first de-high cycle of a line, +1 on each later de-high cycle, and held while de is low.
REQ-018 o_y SHALL be 0 after a vsync edge and +1 on each de falling edge; o_y SHALL wrap 1023->0, with no error raised.
REQ-019 o_pix_valid SHALL be the registered de ANDed with o_locked, aligned to o_x/o_y.
REQ-020 FSM states SEARCH, ACQUIRE and LOCKED; o_locked=1 only in LOCKED.
REQ-021 SEARCH->ACQUIRE on the first vsync edge, clearing the match counter and the frame-bad flag.
REQ-022 In ACQUIRE, any hsync edge with h_cnt+1 != H_TOTAL_EXP SHALL set frame-bad.
REQ-023 In ACQUIRE, at a vsync edge: if frame-bad=0 and v_cnt+1 == V_TOTAL_EXP, the match counter SHALL increment; otherwise it SHALL clear. Frame-bad SHALL then clear.
REQ-024 When the match counter reaches LOCK_FRAMES, the FSM SHALL move from ACQUIRE to LOCKED.
REQ-025 In LOCKED, the FSM SHALL go to SEARCH and pulse o_err on any of the following:
- an hsync edge whose line length mismatches H_TOTAL_EXP;
- a vsync edge whose frame length mismatches V_TOTAL_EXP;
- h_cnt saturating (loss of hsync).
REQ-026 Simultaneous hsync and vsync edges SHALL both be processed in the same cycle; the line check applies before the frame check, and a single o_err pulse is generated.
REQ-027 o_frame_start SHALL pulse in every state, including SEARCH.

Reset
REQ-028 While i_rst_n=0, all outputs SHALL be 0, the FSM SHALL be in SEARCH, and all counters and synchronizer flops SHALL be 0 (sync flops at the inactive level).
REQ-029 Reset asserted mid-frame SHALL abort immediately. After deassertion, lock SHALL require a new vsync edge plus LOCK_FRAMES good frames.

Configuration
REQ-030 Macro VGA_TIMING_RX_ERR_CNT_EN, when defined, SHALL add output o_err_cnt (16 bits), which:
- increments on each o_err pulse;
- saturates at 65535;
- resets to 0.
REQ-031 Without VGA_TIMING_RX_ERR_CNT_EN, the o_err_cnt port and its counter SHALL be absent; all other behaviour is unchanged.

Structure
REQ-032 A shared package vga_pkg SHALL hold:
- the 1024x768 timing constants (active 1024/768, front porch 24/3, sync 136/6, back porch 160/29, totals 1344/806);
- coordinate width constants (11/10);
- the FSM state enum type.
REQ-033 The sub-module vga_edge_sync SHALL implement the per-signal 2-flop register plus leading/trailing-edge detect; it SHALL be instantiated three times.

Verification
REQ-034 Bench SHALL drive the 1024x768 timing (1344x806) from reset -> o_locked rises exactly at the vsync edge ending the 2nd complete frame after the first vsync; o_h_total=1344, o_v_total=806.
REQ-035 Locked, inject one line of 1343 clocks -> o_err pulses once, o_locked falls, FSM goes to SEARCH, relock occurs after 2 further good frames.
REQ-036 Locked, hold hsync inactive for 2100 clocks -> o_err at h_cnt=2047, o_h_total then reads 2047.
REQ-037 Locked, check the first and last active pixels -> o_x=0,o_y=0 and o_x=1023,o_y=767 with o_pix_valid=1; o_pix_valid=0 in blanking.
REQ-038 Drive SYNC_ACT_LOW=0 with inverted syncs -> identical lock timing and totals as REQ-034.
REQ-039 With VGA_TIMING_RX_ERR_CNT_EN defined, force 3 lock losses -> o_err_cnt=3; assert i_rst_n=0 mid-line -> o_err_cnt=0 and all outputs 0 asynchronously.
